// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - OAM DMA engine copying one source page into OAM through the MMU read path
module oam_dma #(
  parameter int READ_LATENCY = 1,
  parameter int XFER_LEN     = 160
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iDmaWe,
  input  logic [7:0]  iDmaData,
  output logic        oDmaReadRequest,
  output logic [15:0] oDmaAddr,
  input  logic [7:0]  iDmaReadData,
  output logic        oOamWe,
  output logic [7:0]  oOamAddr,
  output logic [7:0]  oOamData,
  output logic        oDmaBusy,
  output logic [7:0]  oGPU_DMA
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE
  } state_e;

  // idx never exceeds LAST_IDX, so 8 bits cover a full 256-byte page
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);
  localparam logic [2:0] LAT      = 3'(READ_LATENCY);

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src_q, src_d;
  logic [7:0] gpu_dma_q, gpu_dma_d;
  logic [7:0] data_q, data_d;
  logic [2:0] wait_q, wait_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q   <= S_IDLE;
      idx_q     <= 8'h00;
      src_q     <= 8'h00;
      gpu_dma_q <= 8'h00;
      data_q    <= 8'h00;
      wait_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      src_q     <= src_d;
      gpu_dma_q <= gpu_dma_d;
      data_q    <= data_d;
      wait_q    <= wait_d;
    end
  end

  // Next-state logic: read, wait out the read latency, write; a CPU write restarts from byte 0
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    src_d     = src_q;
    gpu_dma_d = gpu_dma_q;
    data_d    = data_q;
    wait_d    = wait_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_READ: begin
        state_d = S_WAIT;
        wait_d  = LAT;
      end
      S_WAIT: begin
        if (wait_q == 3'd1) begin
          data_d  = iDmaReadData;
          state_d = S_WRITE;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The OAM write of a WRITE cycle is already on the outputs, so it still lands;
    // a byte in flight in READ/WAIT is simply dropped.
    if (iDmaWe) begin
      src_d     = iDmaData;
      gpu_dma_d = iDmaData;
      idx_d     = 8'h00;
      state_d   = S_READ;
    end
  end

  // Outputs decode purely from registered state
  assign oDmaReadRequest = (state_q == S_READ);
  assign oDmaAddr        = (state_q == S_READ || state_q == S_WAIT) ? {src_q, idx_q} : 16'h0000;
  assign oOamWe          = (state_q == S_WRITE);
  assign oOamAddr        = (state_q == S_WRITE) ? idx_q : 8'h00;
  assign oOamData        = (state_q == S_WRITE) ? data_q : 8'h00;
  assign oDmaBusy        = (state_q != S_IDLE);
  assign oGPU_DMA        = gpu_dma_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - scoreboard testbench for oam_dma
module tb_oam_dma;

  logic        clk;
  logic        rst;
  logic [7:0]  dma_data;
  logic        we       [3];
  logic        rd_req   [3];
  logic [15:0] dma_addr [3];
  logic [7:0]  rd_data  [3];
  logic        oam_we   [3];
  logic [7:0]  oam_addr [3];
  logic [7:0]  oam_data [3];
  logic        busy     [3];
  logic [7:0]  gpu      [3];

  int tests = 0;
  int fails = 0;
  int busy_cnt = 0;

  logic [15:0] exp_rd[$];
  logic [15:0] exp_wr[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: defaults, dut1: READ_LATENCY 3, dut2: XFER_LEN 256
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 1) ? 3 : 1;
    localparam int N = (g == 2) ? 256 : 160;

    oam_dma #(.READ_LATENCY(L), .XFER_LEN(N)) u_dut (
      .iClock         (clk),
      .iReset         (rst),
      .iDmaWe         (we[g]),
      .iDmaData       (dma_data),
      .oDmaReadRequest(rd_req[g]),
      .oDmaAddr       (dma_addr[g]),
      .iDmaReadData   (rd_data[g]),
      .oOamWe         (oam_we[g]),
      .oOamAddr       (oam_addr[g]),
      .oOamData       (oam_data[g]),
      .oDmaBusy       (busy[g]),
      .oGPU_DMA       (gpu[g])
    );

    // Memory model: data valid exactly L cycles after the request, junk otherwise
    logic [3:0] pv;
    logic [7:0] pa [4];
    always @(posedge clk) begin
      if (rst) begin
        pv <= 4'b0;
      end else begin
        pv <= {pv[2:0], rd_req[g]};
      end
      pa[0] <= dma_addr[g][7:0];
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
    assign rd_data[g] = pv[L-1] ? (pa[L-1] ^ 8'h5A) : 8'hEE;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every read request and OAM write pops the next expected entry
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rd_req[g] === 1'b1) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", {16'h0, dma_addr[g]}, 32'hFFFF_FFFF);
        else chk("rd_addr", {16'h0, dma_addr[g]}, {16'h0, exp_rd.pop_front()});
      end
      if (oam_we[g] === 1'b1) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", {16'h0, oam_addr[g], oam_data[g]}, 32'hFFFF_FFFF);
        else chk("oam_wr", {16'h0, oam_addr[g], oam_data[g]}, {16'h0, exp_wr.pop_front()});
      end
      if (busy[g] === 1'b1) busy_cnt++;
    end
  end

  task automatic push_rd(input logic [7:0] src, input int n);
    for (int k = 0; k < n; k++) exp_rd.push_back({src, 8'(k)});
  endtask

  task automatic push_wr(input int n);
    for (int k = 0; k < n; k++) exp_wr.push_back({8'(k), 8'(k) ^ 8'h5A});
  endtask

  // Drive the register write during the current cycle; returns in cycle 1
  task automatic start(input int g, input logic [7:0] d);
    dma_data = d;
    we[g] = 1'b1;
    @(posedge clk); #1;
    we[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (busy[g] === 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", {31'h0, busy[g]}, 32'h0);
  endtask

  task automatic chk_drained(input string name);
    chk({name, "_rd_left"}, exp_rd.size(), 0);
    chk({name, "_wr_left"}, exp_wr.size(), 0);
  endtask

  task automatic chk_zero(input int g);
    chk("z_rdreq", {31'h0, rd_req[g]}, 0);
    chk("z_addr", {16'h0, dma_addr[g]}, 0);
    chk("z_we", {31'h0, oam_we[g]}, 0);
    chk("z_oaddr", {24'h0, oam_addr[g]}, 0);
    chk("z_odata", {24'h0, oam_data[g]}, 0);
    chk("z_busy", {31'h0, busy[g]}, 0);
    chk("z_gpu", {24'h0, gpu[g]}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    dma_data = 8'h00;
    for (int g = 0; g < 3; g++) we[g] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < 3; g++) chk_zero(g);

    // Default full transfer from 0xC000 with cycle-exact timing
    push_rd(8'hC0, 160);
    push_wr(160);
    busy_cnt = 0;
    start(0, 8'hC0);
    chk("t1_busy_c1", {31'h0, busy[0]}, 1);
    chk("t1_req_c1", {31'h0, rd_req[0]}, 1);
    chk("t1_gpu", {24'h0, gpu[0]}, 32'hC0);
    repeat (2) @(posedge clk); #1;
    chk("t1_we_c3", {31'h0, oam_we[0]}, 1);
    repeat (477) @(posedge clk); #1;
    chk("t1_busy_c480", {31'h0, busy[0]}, 1);
    @(posedge clk); #1;
    chk("t1_busy_c481", {31'h0, busy[0]}, 0);
    chk("t1_busy_cnt", busy_cnt, 480);
    chk_drained("t1");

    // READ_LATENCY 3: five cycles per byte
    push_rd(8'hC0, 160);
    push_wr(160);
    busy_cnt = 0;
    start(1, 8'hC0);
    wait_idle(1);
    chk("t2_busy_cnt", busy_cnt, 800);
    chk_drained("t2");

    // Restart during WAIT of byte 37 (cycle 113)
    push_rd(8'hC0, 38);
    push_wr(37);
    push_rd(8'hC1, 160);
    push_wr(160);
    start(0, 8'hC0);
    repeat (112) @(posedge clk); #1;
    start(0, 8'hC1);
    chk("t3_gpu", {24'h0, gpu[0]}, 32'hC1);
    wait_idle(0);
    chk_drained("t3");

    // Restart in the WRITE cycle of byte 10 (cycle 33)
    push_rd(8'hC0, 11);
    push_wr(11);
    push_rd(8'hD0, 160);
    push_wr(160);
    start(0, 8'hC0);
    repeat (32) @(posedge clk); #1;
    start(0, 8'hD0);
    chk("t4_addr", {16'h0, dma_addr[0]}, 32'hD000);
    wait_idle(0);
    chk("t4_gpu", {24'h0, gpu[0]}, 32'hD0);
    chk_drained("t4");

    // Reset during READ of byte 50 (cycle 151), colliding with a register write
    push_rd(8'hC0, 51);
    push_wr(50);
    start(0, 8'hC0);
    repeat (150) @(posedge clk); #1;
    rst = 1'b1;
    we[0] = 1'b1;
    dma_data = 8'h77;
    @(posedge clk); #1;
    rst = 1'b0;
    we[0] = 1'b0;
    chk_zero(0);
    repeat (20) @(posedge clk); #1;
    chk_drained("t5");

    push_rd(8'h80, 160);
    push_wr(160);
    busy_cnt = 0;
    start(0, 8'h80);
    wait_idle(0);
    chk("t5_busy_cnt", busy_cnt, 480);
    chk("t5_gpu", {24'h0, gpu[0]}, 32'h80);
    chk_drained("t5b");

    // Full 256-byte page from 0xFF00 with no wrap
    push_rd(8'hFF, 256);
    push_wr(256);
    busy_cnt = 0;
    start(2, 8'hFF);
    wait_idle(2);
    chk("t6_busy_cnt", busy_cnt, 768);
    chk("t6_addr_idle", {16'h0, dma_addr[2]}, 0);
    chk_drained("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine: the bus initiator that services CPU writes to the DMA register (0xFF46). On each trigger it copies XFER_LEN bytes from source page {DMA, 8'h00} through the MMU read path into OAM (0xFE00 + index). While it runs it signals the MMU to lock out CPU bus access, and it supplies the DMA register readback value to the LCD register read mux.

## Interface
- READ_LATENCY, 1: cycles from read request/address to valid iDmaReadData (1 for the synchronous RAM/BIOS paths); legal 1..4.
- XFER_LEN, 160: bytes per transfer; legal 1..256.
- iClock  in  1  system clock, all state updates on rising edge.
- iReset  in  1  synchronous, active-high reset.
- iDmaWe  in  1  one-cycle strobe: CPU write to 0xFF46 decoded by MMU.
- iDmaData  in  8  CPU write data; becomes source page high byte.
- oDmaReadRequest  out  1  read request to MMU read path.
- oDmaAddr  out  16  source address {src, 8'h00} + index.
- iDmaReadData  in  8  read data from MMU, valid READ_LATENCY cycles after request.
- oOamWe  out  1  OAM write strobe.
- oOamAddr  out  8  OAM byte index (0xFE00 + oOamAddr).
- oOamData  out  8  OAM write data.
- oDmaBusy  out  1  transfer in progress; MMU blocks CPU accesses except 0xFF80-0xFFFE.
- oGPU_DMA  out  8  DMA register readback (feeds iGPU_DMA).

## Operation
- State machine: IDLE, READ, WAIT, WRITE.
- IDLE: all strobes low. iDmaWe -> latch src = iDmaData, oGPU_DMA = iDmaData, idx = 0, next READ.
- READ (1 cycle): oDmaReadRequest = 1, oDmaAddr = {src, idx}. Next WAIT, wait counter = READ_LATENCY.
- WAIT (READ_LATENCY cycles): oDmaAddr held. On the last WAIT cycle, capture iDmaReadData into the data register. Next WRITE.
- WRITE (1 cycle): oOamWe = 1, oOamAddr = idx, oOamData = captured byte.
  - idx == XFER_LEN-1 -> IDLE.
  - Otherwise idx += 1, next READ.
- oDmaBusy = (state != IDLE).
- All outputs decode from registers only. No combinational path from any input to any output.
- Address arithmetic: idx is 8 bits and never exceeds XFER_LEN-1. oDmaAddr low byte = idx with no carry into src. Any src 0x00-0xFF is accepted unmodified; echo/illegal-region mapping belongs to the MMU.
- Restart: iDmaWe in any non-IDLE state reloads src and oGPU_DMA, sets idx = 0, next READ.
  - A WRITE in progress in that same cycle still completes its OAM write.
  - A byte in READ/WAIT is discarded and never written.
- No clear or abort input exists. A transfer ends only by completion, restart, or reset.

## Timing
- Reset values: state IDLE, idx 0, src 0, oGPU_DMA 0x00, data register 0. All outputs 0: oDmaReadRequest, oDmaAddr, oOamWe, oOamAddr, oOamData, oDmaBusy.
- iReset mid-transfer: IDLE on the next edge and no further OAM writes. iReset wins over a simultaneous iDmaWe.
- Cycle numbering: iDmaWe sampled at edge 0; oDmaBusy and the first oDmaReadRequest are high in cycle 1.
- Per byte: 2 + READ_LATENCY cycles. With defaults, 3 cycles/byte and 480 cycles total.
- Default timing: byte n's oOamWe is high in cycle 3n+3. oDmaBusy falls in cycle 481 (first cycle back in IDLE).
- oDmaAddr is stable from READ through WAIT; iDmaReadData is don't-care outside the capture cycle.
- oOamWe is high for exactly one cycle per byte; oOamAddr/oOamData are valid only while it is high.
- oGPU_DMA updates in the cycle after iDmaWe and holds until the next write or reset.

## Test plan
- Defaults, memory model returns byte = low address XOR 0x5A, write 0xC0 -> 160 OAM writes, addr k = k, data k^0x5A, source 0xC000+k; busy exactly cycles 1..480; oGPU_DMA reads 0xC0.
- READ_LATENCY = 3 -> 5 cycles/byte; each capture uses data presented exactly 3 cycles after its request; 800 busy cycles.
- Write 0xC1 during WAIT of byte 37 -> byte 37 never written; next request is 0xC100; then 160 writes from 0xC100.
- Write 0xD0 in the same cycle as WRITE of byte 10 -> byte 10 still written; restart at 0xD000, idx 0.
- iReset at byte 50 -> no oOamWe afterward; all outputs 0; oGPU_DMA 0x00. A later write 0x80 runs a full transfer normally.
- src 0xFF, XFER_LEN = 256 -> addresses 0xFF00..0xFFFF with no wrap into 0x0000; last oOamAddr 0xFF, then IDLE.
